// File: rtl/rr_mux4_arbiter.sv
// Four-way round-robin arbiter that drives a shared 4:1 mux, holds each grant for a whole
// packet, and forwards beats through a registered valid/ready output stage.
module rr_mux4_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [3:0]       last,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [3:0]       ack,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [1:0]       out_src,
    input  logic             out_ready
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t           state, state_nxt;
    logic [3:0]       gnt_nxt;
    logic [1:0]       sel_nxt;
    logic [1:0]       rr_ptr, rr_ptr_nxt;
    logic [1:0]       cand;
    logic [1:0]       pick;
    logic             pick_found;
    logic             space;
    logic             accept;
    logic [WIDTH-1:0] mux_data;

    // Scan starts just after the last served requester, so it gets lowest priority.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        cand       = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = rr_ptr + 2'(k);
            if (!pick_found && req[cand]) begin
                pick       = cand;
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        mux_data = '0;
        case (sel)
            2'd0:    mux_data = d0;
            2'd1:    mux_data = d1;
            2'd2:    mux_data = d2;
            default: mux_data = d3;
        endcase
    end

    assign space  = !out_valid || out_ready;
    assign accept = (state == LOCKED) && req[sel] && space;
    assign ack    = accept ? (4'b0001 << sel) : 4'b0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            gnt    <= '0;
            sel    <= '0;
            rr_ptr <= 2'd3;
        end else begin
            state  <= state_nxt;
            gnt    <= gnt_nxt;
            sel    <= sel_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        gnt_nxt    = gnt;
        sel_nxt    = sel;
        rr_ptr_nxt = rr_ptr;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    gnt_nxt   = 4'b0001 << pick;
                    sel_nxt   = pick;
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (accept && last[sel]) begin
                    rr_ptr_nxt = sel;
                    gnt_nxt    = '0;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= mux_data;
            out_last  <= last[sel];
            out_src   <= sel;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Scoreboard bench for rr_mux4_arbiter: packets are queued per requester, the expected
// output stream and grant order come from a packet-level round-robin model.
module tb_rr_mux4_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [31:0] d0, d1, d2, d3;
    logic [3:0]  ack;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic [1:0]  out_src;
    logic        out_ready;

    rr_mux4_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .req(req), .last(last),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .ack(ack), .gnt(gnt), .sel(sel),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_src(out_src), .out_ready(out_ready)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [1:0]  src;
    } exp_t;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rdy_mode = 0;   // 0: ready held high, 1: held low, 2: random

    // Per-requester beat storage consumed by the driver.
    logic [31:0] bd [4][1024];
    logic        bl [4][1024];
    int          bg [4][1024];
    int          wr [4];
    int          rd [4];
    int          gapc [4];

    // Model's view of pending packets.
    int pk_s [4][256];
    int pk_n [4][256];
    int pk_rd [4];
    int pk_wr [4];
    int m_last = 3;

    exp_t exp_q[$];
    int   grant_q[$];
    int   hs_t[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add_packet(input int src, input int n, input logic [31:0] base,
                              input logic [31:0] step, input int gap);
        pk_s[src][pk_wr[src]] = wr[src];
        pk_n[src][pk_wr[src]] = n;
        pk_wr[src]++;
        for (int b = 0; b < n; b++) begin
            bd[src][wr[src]] = base + step * 32'(b);
            bl[src][wr[src]] = (b == n - 1);
            bg[src][wr[src]] = (b == 0) ? 0 : gap;
            wr[src]++;
        end
    endtask

    // Whole packets are served in round-robin order over requesters with packets pending.
    task automatic plan();
        int idx;
        bit found;
        forever begin
            found = 1'b0;
            idx   = 0;
            for (int k = 1; k <= 4; k++) begin
                if (!found && pk_rd[(m_last + k) % 4] < pk_wr[(m_last + k) % 4]) begin
                    idx   = (m_last + k) % 4;
                    found = 1'b1;
                end
            end
            if (!found) break;
            grant_q.push_back(idx);
            for (int b = 0; b < pk_n[idx][pk_rd[idx]]; b++) begin
                exp_q.push_back('{data: bd[idx][pk_s[idx][pk_rd[idx]] + b],
                                  last: bl[idx][pk_s[idx][pk_rd[idx]] + b],
                                  src:  2'(idx)});
            end
            pk_rd[idx]++;
            m_last = idx;
        end
    endtask

    function automatic bit drained();
        bit d;
        d = (exp_q.size() == 0) && (grant_q.size() == 0) && (gnt == 4'b0000);
        for (int i = 0; i < 4; i++) if (rd[i] != wr[i]) d = 1'b0;
        return d;
    endfunction

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (!drained() && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!drained()) begin
            failures++;
            $display("FAIL %s_drain actual=pending(%0d beats) required=empty within %0d cycles",
                     name, exp_q.size(), budget);
        end
    endtask

    // Driver: advances a requester on an ack seen before the edge, inserts mid-packet gaps.
    initial begin
        logic [3:0]  acc;
        logic [31:0] dv [4];
        bit          have;
        req = '0; last = '0; d0 = '0; d1 = '0; d2 = '0; d3 = '0; out_ready = 1'b1;
        forever begin
            @(negedge clk);
            acc = ack;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (acc[i] && rd[i] < wr[i]) begin
                    rd[i]++;
                    gapc[i] = (rd[i] < wr[i]) ? bg[i][rd[i]] : 0;
                end else if (gapc[i] > 0) begin
                    gapc[i]--;
                end
                have    = rd[i] < wr[i];
                req[i]  = have && gapc[i] == 0;
                last[i] = have && bl[i][rd[i]];
                dv[i]   = have ? bd[i][rd[i]] : 32'h0;
            end
            d0 = dv[0]; d1 = dv[1]; d2 = dv[2]; d3 = dv[3];
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: grant order, ack legality, output stability and beat stream.
    initial begin
        exp_t        e;
        int          g;
        logic        p_valid, p_ready;
        logic [3:0]  p_gnt;
        logic [31:0] p_data;
        logic        p_last;
        logic [1:0]  p_src;
        p_valid = 0; p_ready = 0; p_gnt = '0; p_data = '0; p_last = 0; p_src = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                p_valid = 0; p_ready = 0; p_gnt = '0;
                continue;
            end
            if (gnt != 4'b0000 && p_gnt == 4'b0000) begin
                if (grant_q.size() == 0) begin
                    chk("grant_unexpected", 32'(gnt), 32'h0);
                end else begin
                    g = grant_q.pop_front();
                    chk("grant_gnt", 32'(gnt), 32'(1 << g));
                    chk("grant_sel", 32'(sel), 32'(g));
                end
            end
            if (ack != 4'b0000) begin
                chk("ack_in_gnt", 32'(ack & ~gnt), 32'h0);
                chk("ack_onehot", 32'($countones(ack)), 32'd1);
            end
            if (p_valid && !p_ready) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", out_data, p_data);
                chk("hold_last", 32'(out_last), 32'(p_last));
                chk("hold_src", 32'(out_src), 32'(p_src));
            end
            if (out_valid && out_ready) begin
                hs_t.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("out_unexpected", out_data, 32'hFFFF_FFFF ^ out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_last", 32'(out_last), 32'(e.last));
                    chk("out_src", 32'(out_src), 32'(e.src));
                end
            end
            p_valid = out_valid; p_ready = out_ready; p_gnt = gnt;
            p_data = out_data; p_last = out_last; p_src = out_src;
        end
    end

    initial begin
        int n;
        for (int i = 0; i < 4; i++) begin
            wr[i] = 0; rd[i] = 0; gapc[i] = 0; pk_rd[i] = 0; pk_wr[i] = 0;
        end
        rst = 1'b1;

        // Reset state with every requester asserting; then single-beat round robin.
        for (int i = 0; i < 4; i++) add_packet(i, 1, 32'hA0 + 32'(i), 32'h0, 0);
        add_packet(0, 1, 32'hA0, 32'h0, 0);
        plan();
        repeat (3) @(negedge clk);
        chk("rst_req_driven", 32'(req), 32'hF);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        hs_t.delete();
        rst = 1'b0;
        wait_drain("rr", 200);
        chk("rr_beats", 32'(hs_t.size()), 32'd5);
        for (int k = 1; k < hs_t.size(); k++) chk("rr_spacing", 32'(hs_t[k] - hs_t[k-1]), 32'd2);

        // Packet lock: requester 2 holds the grant for three beats while 0 waits.
        add_packet(2, 3, 32'h11, 32'h11, 0);
        add_packet(0, 1, 32'h44, 32'h0, 0);
        plan();
        wait_drain("lock", 200);

        // Backpressure on a four-beat packet, then full-rate drain.
        rdy_mode = 1;
        add_packet(0, 4, 32'h41, 32'h1, 0);
        plan();
        n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        chk("bp_valid", 32'(out_valid), 32'd1);
        repeat (3) @(negedge clk);
        chk("bp_data", out_data, 32'h41);
        chk("bp_ack", 32'(ack), 32'h0);
        hs_t.delete();
        rdy_mode = 0;
        wait_drain("bp", 200);
        chk("bp_beats", 32'(hs_t.size()), 32'd4);
        for (int k = 1; k < hs_t.size(); k++) chk("bp_spacing", 32'(hs_t[k] - hs_t[k-1]), 32'd1);

        // Mid-packet gap on requester 1 while requester 3 waits.
        add_packet(1, 2, 32'h51, 32'h1, 5);
        add_packet(3, 1, 32'h53, 32'h0, 0);
        plan();
        n = 0;
        while (gnt != 4'b0010 && n < 50) begin @(negedge clk); n++; end
        chk("gap_grant", 32'(gnt), 32'h2);
        repeat (3) @(negedge clk);
        chk("gap_hold_gnt", 32'(gnt), 32'h2);
        chk("gap_ack", 32'(ack), 32'h0);
        wait_drain("gap", 200);

        // Randomised packets, gaps and backpressure.
        rdy_mode = 2;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 4; i++) begin
                for (int p = 0; p < int'($urandom_range(0, 3)); p++)
                    add_packet(i, int'($urandom_range(1, 4)), $urandom, $urandom,
                               int'($urandom_range(0, 2)));
            end
            plan();
            wait_drain("rand", 3000);
        end

        // Asynchronous reset while locked on requester 3 with a beat held.
        rdy_mode = 1;
        add_packet(3, 4, 32'h61, 32'h1, 0);
        plan();
        n = 0;
        while (!(gnt == 4'b1000 && out_valid) && n < 50) begin @(negedge clk); n++; end
        chk("ar_locked", 32'(gnt), 32'h8);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'h0);
        chk("ar_gnt", 32'(gnt), 32'h0);
        chk("ar_ack", 32'(ack), 32'h0);
        for (int i = 0; i < 4; i++) begin
            rd[i] = wr[i]; gapc[i] = 0; pk_rd[i] = pk_wr[i];
        end
        exp_q.delete();
        grant_q.delete();
        m_last = 3;
        @(negedge clk);
        rdy_mode = 0;
        for (int i = 0; i < 4; i++) add_packet(i, 1, 32'h70 + 32'(i), 32'h0, 0);
        plan();
        @(negedge clk);
        rst = 1'b0;
        wait_drain("after_reset", 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_mux4_arbiter.md
Name: rr_mux4_arbiter

Overview:
Round-robin arbiter that shares one 4:1 datapath mux between four requesters and drives the mux select. Each requester presents a packet of beats (data + last) with a req/ack handshake. The arbiter locks its grant for a whole packet and forwards beats through a registered valid/ready output stage. It sits in front of any shared single-consumer resource, such as a bus port or write buffer.

Parameters:
WIDTH, 32, data width of each requester beat and of out_data.

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
req  input  4  req[i]: requester i has a valid beat on d_i/last[i]
last  input  4  last[i]: current beat of requester i ends its packet
d0  input  WIDTH  requester 0 beat data
d1  input  WIDTH  requester 1 beat data
d2  input  WIDTH  requester 2 beat data
d3  input  WIDTH  requester 3 beat data
ack  output  4  ack[i]: beat of requester i accepted this cycle (combinational)
gnt  output  4  one-hot current grant, registered; 0 when idle
sel  output  2  registered mux select = index of granted requester
out_valid  output  1  output register holds a beat
out_data  output  WIDTH  registered beat data
out_last  output  1  registered last flag
out_src  output  2  requester index of the beat in the output register
out_ready  input  1  downstream accepts the output beat this cycle

Behaviour:
- Reset (async, rst=1): state=IDLE, gnt=0, sel=0, rr_ptr=3 (so requester 0 has first priority), out_valid=0, out_data=0, out_last=0, out_src=0. ack=0 while rst is asserted.
- Reset mid-packet: the in-flight packet and the output beat are discarded, with no completion.
- FSM states:
  - IDLE: if req!=0, pick the first set req scanning rr_ptr+1, rr_ptr+2, ... (mod 4). Register gnt/sel, go LOCKED. No ack in IDLE; arbitration costs exactly 1 cycle.
  - LOCKED: only requester sel may transfer. If last[sel] is accepted, set rr_ptr=sel and go IDLE (1-cycle bubble before the next grant). If req[sel] drops mid-packet, stay LOCKED indefinitely; no other requester is served.
- Accept condition:
  - space = !out_valid | out_ready.
  - ack[i] = (state==LOCKED) & (sel==i) & req[i] & space. At most one ack bit is set.
- Output register update:
  - On acceptance: out_data<=d_sel, out_last<=last[sel], out_src<=sel, out_valid<=1.
  - Else if out_ready: out_valid<=0 and out_data/out_last/out_src hold.
  - Simultaneous out_ready and acceptance: the old beat leaves and the new beat loads; full throughput is 1 beat/cycle within a packet.
- Latency: a beat accepted in cycle N appears on out_valid/out_data in cycle N+1.
- Stability: while out_valid=1 and out_ready=0, out_data/out_last/out_src are stable.
- Requesters not granted see ack=0 and must hold req/data. Requesters may assert or deassert req at any time; req changes never alter an existing grant.
- Fairness: after a packet from requester k completes, k has the lowest priority at the next arbitration. Any continuously requesting port is granted within 3 packets.
- Single-beat packets: req and last asserted together give an IDLE -> LOCKED -> IDLE sequence, i.e. 1 beat per 2 cycles.
- No combinational path from out_ready to gnt/sel; the only combinational path from out_ready is to ack.

Test Plan:
1. Reset state: assert rst with req=4'b1111 -> gnt=0, sel=0, ack=0, out_valid=0, out_data=0. Release rst with req=4'b1111 and out_ready=1 -> first grant is gnt=0001.
2. Round robin, single-beat packets: req=4'b1111, last=4'b1111, d_i=32'hA0+i, out_ready=1 held -> out_data sequence A0,A1,A2,A3,A0, with out_src 0,1,2,3,0 and one beat every 2 cycles.
3. Packet lock: requester 2 sends 3 beats (11,22,33, last on 33) while req[0] is held high -> gnt stays 0100 for all 3 beats and ack[0]=0 throughout. Requester 0 is granted the cycle after the bubble, and out_last=1 only with 33.
4. Backpressure: out_ready=0 during a 4-beat packet -> the first beat is accepted and the second sees ack=0. out_data holds the first beat unchanged. Set out_ready=1 -> remaining beats stream at 1/cycle with none lost or duplicated.
5. Gap mid-packet: req[1] drops for 5 cycles before its last beat while req[3]=1 -> gnt stays 0010 and ack[3]=0. Requester 1 completes, then gnt=1000.
6. Async reset mid-packet: pulse rst between clock edges while LOCKED on requester 3 with out_valid=1 -> out_valid=0 and gnt=0 immediately. After release, arbitration restarts with requester 0 highest priority.
